cache_fill_fsm: RTL

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm_pkg.sv | 30 +++
 rtl/cache_fill_fsm_if.sv | 36 +++
 rtl/cache_fill_fsm_fill_counter.sv | 26 ++
 rtl/cache_fill_fsm.sv | 89 ++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: fill FSM states, block geometry, address field positions
// and the victim-way selection rule.
package cache_fill_fsm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_TAGWR = 2'd3
    } fill_state_e;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int ADDR_W          = 16;
    localparam int WORD_W          = 16;
    localparam int META_W          = 8;
    localparam int TAG_MSB         = 15;
    localparam int TAG_LSB         = 10;
    localparam int INDEX_MSB       = 9;
    localparam int INDEX_LSB       = 4;
    localparam int TAG_W           = TAG_MSB - TAG_LSB + 1;
    localparam int INDEX_W         = INDEX_MSB - INDEX_LSB + 1;
    localparam int BLK_W           = TAG_MSB - INDEX_LSB + 1;

    // 0 = way0, 1 = way1. Invalid ways first, then the way whose LRU bit points away from way0.
    function automatic logic pick_victim(input logic [META_W-1:0] meta0,
                                         input logic [META_W-1:0] meta1);
        return meta0[0] & (~meta1[0] | ~meta0[1]);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bus between the block-fill FSM and its surroundings (lookup, metadata/data arrays, memory).
interface cache_fill_fsm_if;
    import cache_fill_fsm_pkg::*;

    logic                       miss_detected;
    logic [ADDR_W-1:0]          miss_address;
    logic [META_W-1:0]          meta0;
    logic [META_W-1:0]          meta1;
    logic                       memory_data_valid;
    logic [WORD_W-1:0]          memory_data;

    logic                       fsm_busy;
    logic                       mem_read;
    logic [ADDR_W-1:0]          memory_address;
    logic [INDEX_W-1:0]         set_index;
    logic                       data_write0;
    logic                       data_write1;
    logic [WORDS_PER_BLOCK-1:0] word_enable;
    logic [WORD_W-1:0]          data_out;
    logic                       tag_write0;
    logic                       tag_write1;
    logic [META_W-1:0]          tag_out;

    modport master (
        input  miss_detected, miss_address, meta0, meta1, memory_data_valid, memory_data,
        output fsm_busy, mem_read, memory_address, set_index, data_write0, data_write1,
               word_enable, data_out, tag_write0, tag_write1, tag_out
    );

    modport slave (
        output miss_detected, miss_address, meta0, meta1, memory_data_valid, memory_data,
        input  fsm_busy, mem_read, memory_address, set_index, data_write0, data_write1,
               word_enable, data_out, tag_write0, tag_write1, tag_out
    );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// 3-bit word counter with synchronous clear (priority) and count enable.
module fill_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [2:0] cnt_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Two-way cache block fill: issues eight word reads, streams returns into the victim way,
// then writes the new tag with valid set.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = cache_fill_fsm_pkg::WORDS_PER_BLOCK,
    parameter int MEM_LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    cache_fill_fsm_if.master  bus
);
    import cache_fill_fsm_pkg::*;

    if (WORDS_PER_BLOCK != 8 || MEM_LATENCY < 0) begin : g_cfg_check
        $error("cache_fill_fsm: 3-bit word counters require 8-word blocks");
    end

    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);

    fill_state_e       state_q;
    logic [BLK_W-1:0]  blk_q;
    logic              victim_q;
    logic [2:0]        req_cnt;
    logic [2:0]        ret_cnt;
    logic              busy;
    logic              start;
    logic              accept;
    logic              tagwr;

    assign busy   = (state_q != S_IDLE);
    assign start  = (state_q == S_IDLE) && bus.miss_detected;
    assign accept = ((state_q == S_REQ) || (state_q == S_WAIT)) && bus.memory_data_valid;
    assign tagwr  = (state_q == S_TAGWR);

    fill_counter u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start),
        .en_i  (state_q == S_REQ),
        .cnt_o (req_cnt)
    );

    fill_counter u_ret_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start),
        .en_i  (accept),
        .cnt_o (ret_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            blk_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.miss_detected) begin
                    state_q  <= S_REQ;
                    blk_q    <= bus.miss_address[TAG_MSB:INDEX_LSB];
                    victim_q <= pick_victim(bus.meta0, bus.meta1);
                end
                // A short memory latency can deliver the last word before requests finish.
                S_REQ: begin
                    if (accept && ret_cnt == LAST_WORD) state_q <= S_TAGWR;
                    else if (req_cnt == LAST_WORD)      state_q <= S_WAIT;
                end
                S_WAIT:  if (accept && ret_cnt == LAST_WORD) state_q <= S_TAGWR;
                S_TAGWR: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.fsm_busy       = busy;
        bus.mem_read       = (state_q == S_REQ);
        bus.memory_address = '0;
        if (state_q == S_REQ) bus.memory_address = {blk_q, req_cnt, 1'b0};
        bus.set_index      = busy ? blk_q[INDEX_W-1:0] : bus.miss_address[INDEX_MSB:INDEX_LSB];
        bus.data_write0    = accept & ~victim_q;
        bus.data_write1    = accept & victim_q;
        bus.word_enable    = accept ? ({{(WORDS_PER_BLOCK-1){1'b0}}, 1'b1} << ret_cnt) : '0;
        bus.data_out       = accept ? bus.memory_data : '0;
        bus.tag_write0     = tagwr & ~victim_q;
        bus.tag_write1     = tagwr & victim_q;
        bus.tag_out        = tagwr ? {blk_q[BLK_W-1 -: TAG_W], 2'b11} : '0;
    end

endmodule
